// File: rtl/row_scan_ctrl_if.sv
// row_scan_ctrl_if: host request/grant handshake for exclusive row access
interface row_scan_ctrl_if;
  logic       req;
  logic [2:0] req_addr;
  logic       done;
  logic       gnt;
  modport master (output req, req_addr, done, input gnt);
  modport slave (input req, req_addr, done, output gnt);
endinterface

// File: rtl/row_scan_ctrl.sv
// row_scan_ctrl: scans a 3-to-8 row decoder with dwell/blanking and grants rows to a host at row boundaries
module row_scan_ctrl #(
  parameter int NROWS     = 8,
  parameter int DWELL_W   = 8,
  parameter int BLANK_CYC = 2
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  row_scan_ctrl_if.slave     host,
  output logic [2:0]         addr,
  output logic               nen,
  output logic               frame_tick,
  output logic               busy
);
  localparam int BW = $clog2(BLANK_CYC + 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);
  localparam logic [BW-1:0] B_ONE = BW'(1);
  localparam logic [DWELL_W-1:0] D_ONE = DWELL_W'(1);
  localparam logic [2:0] LAST_ROW = 3'(NROWS - 1);
  localparam logic [3:0] NR = 4'(NROWS);

  typedef enum logic [1:0] {IDLE, ACTIVE, BLANK, HOST} state_t;

  state_t             state, state_n;
  logic [2:0]         row, row_n, addr_n, nxt_row;
  logic               resume, resume_n, nen_n, gnt_n, tick_n, host_off;
  logic [DWELL_W-1:0] dcnt, dcnt_n, dwell_ld;
  logic [BW-1:0]      bcnt, bcnt_n;

  assign dwell_ld = (dwell == '0) ? '0 : dwell - D_ONE;
  assign host_off = {1'b0, host.req_addr} >= NR;
  assign nxt_row  = resume ? row : (row == LAST_ROW ? 3'd0 : row + 3'd1);

  // next state and next registered outputs; host is only admitted from IDLE or at a blank exit
  always_comb begin
    state_n  = state;
    row_n    = row;
    resume_n = resume;
    dcnt_n   = dcnt;
    bcnt_n   = bcnt;
    addr_n   = addr;
    nen_n    = nen;
    gnt_n    = host.gnt;
    tick_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (host.req) begin
          state_n = HOST;
          addr_n  = host.req_addr;
          nen_n   = host_off;
          gnt_n   = 1'b1;
        end else if (en) begin
          state_n = ACTIVE;
          row_n   = 3'd0;
          addr_n  = 3'd0;
          nen_n   = 1'b0;
          dcnt_n  = dwell_ld;
        end
      end
      ACTIVE: begin
        if (dcnt == '0) begin
          state_n = BLANK;
          nen_n   = 1'b1;
          bcnt_n  = BLANK_LAST;
        end else begin
          dcnt_n = dcnt - D_ONE;
        end
      end
      BLANK: begin
        if (bcnt != '0) begin
          bcnt_n = bcnt - B_ONE;
        end else if (host.req) begin
          state_n = HOST;
          addr_n  = host.req_addr;
          nen_n   = host_off;
          gnt_n   = 1'b1;
        end else if (!en) begin
          state_n  = IDLE;
          row_n    = 3'd0;
          addr_n   = 3'd0;
          resume_n = 1'b0;
        end else begin
          state_n  = ACTIVE;
          row_n    = nxt_row;
          addr_n   = nxt_row;
          nen_n    = 1'b0;
          dcnt_n   = dwell_ld;
          resume_n = 1'b0;
          tick_n   = !resume && row == LAST_ROW;
        end
      end
      HOST: begin
        if (host.done) begin
          state_n  = BLANK;
          gnt_n    = 1'b0;
          nen_n    = 1'b1;
          resume_n = 1'b1;
          bcnt_n   = BLANK_LAST;
        end
      end
    endcase
  end

  // state and all outputs registered; reset blanks the decoder and drops the grant immediately
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      row        <= 3'd0;
      resume     <= 1'b0;
      dcnt       <= '0;
      bcnt       <= '0;
      addr       <= 3'd0;
      nen        <= 1'b1;
      host.gnt   <= 1'b0;
      frame_tick <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      row        <= row_n;
      resume     <= resume_n;
      dcnt       <= dcnt_n;
      bcnt       <= bcnt_n;
      addr       <= addr_n;
      nen        <= nen_n;
      host.gnt   <= gnt_n;
      frame_tick <= tick_n;
      busy       <= state_n != IDLE;
    end
  end
endmodule
